// File: rtl/jk_drive_sequencer.sv
// rtl/jk_drive_sequencer.sv - buffered target-Q sequencer driving an external JK flip-flop
module jk_drive_sequencer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_bit,
  output logic                     in_ready,
  input  logic                     go,
  input  logic                     err_clr,
  output logic                     ff_enabled,
  output logic                     ff_j,
  output logic                     ff_k,
  input  logic                     ff_q,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     err,
  output logic [CNT_W-1:0]         err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DEPTH-1:0]  mem_q, mem_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              exp_q, exp_d;
  logic              en_q, en_d;
  logic              j_q, j_d;
  logic              k_q, k_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              push;
  logic              pop;
  logic              target;
  logic              mismatch;

  assign in_ready = (count_q != FULL_CNT);
  assign push     = in_valid && in_ready;
  assign target   = mem_q[rd_ptr_q];
  // Feedback is only meaningful two edges after the issue edge, i.e. in CHECK.
  assign mismatch = (state_q == S_CHECK) && (ff_q != exp_q);

  // Next-state and command generation; a command is issued from IDLE or CHECK.
  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    j_d     = 1'b0;
    k_d     = 1'b0;
    exp_d   = exp_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE, S_CHECK: begin
        if (go && (count_q != '0)) begin
          pop     = 1'b1;
          en_d    = 1'b1;
          // Excitation with don't-cares forced to 0: set only on 0->1, reset only on 1->0.
          j_d     = ~ff_q & target;
          k_d     = ff_q & ~target;
          exp_d   = target;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT:  state_d = S_CHECK;
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping; a full FIFO refuses pushes even when popping on the same edge.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_bit;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Sticky error flag and saturating counter; a clear loses to a same-edge mismatch.
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (err_clr) begin
      err_d = 1'b0;
      cnt_d = '0;
    end
    if (mismatch) begin
      err_d = 1'b1;
      if (cnt_d != '1) begin
        cnt_d = cnt_d + CNT_W'(1);
      end
    end
  end

  // State, FIFO and output registers with immediate asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      exp_q    <= 1'b0;
      en_q     <= 1'b0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      exp_q    <= exp_d;
      en_q     <= en_d;
      j_q      <= j_d;
      k_q      <= k_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ff_enabled = en_q;
  assign ff_j       = j_q;
  assign ff_k       = k_q;
  assign busy       = (state_q != S_IDLE);
  assign fill       = count_q;
  assign err        = err_q;
  assign err_count  = cnt_q;

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// tb/tb_jk_drive_sequencer.sv - scoreboard bench for jk_drive_sequencer with a behavioural FF_JK
module tb_jk_drive_sequencer;

  localparam int DEPTH   = 8;
  localparam int CNT_W   = 8;
  localparam int S_DEPTH = 4;
  localparam int S_CNT_W = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       in_valid, in_bit, go, err_clr;
  logic       in_ready, ff_enabled, ff_j, ff_k, ff_q, busy, err;
  logic [3:0] fill;
  logic [7:0] err_count;

  logic       s_in_valid, s_in_bit, s_go, s_err_clr;
  logic       s_ff_q;
  logic       s_in_ready, s_ff_enabled, s_ff_j, s_ff_k, s_busy, s_err;
  logic [2:0] s_fill;
  logic [1:0] s_err_count;

  jk_drive_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .go(go), .err_clr(err_clr), .ff_enabled(ff_enabled), .ff_j(ff_j), .ff_k(ff_k),
    .ff_q(ff_q), .busy(busy), .fill(fill), .err(err), .err_count(err_count)
  );

  jk_drive_sequencer #(.DEPTH(S_DEPTH), .CNT_W(S_CNT_W)) u_sat (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_bit(s_in_bit), .in_ready(s_in_ready),
    .go(s_go), .err_clr(s_err_clr), .ff_enabled(s_ff_enabled), .ff_j(s_ff_j), .ff_k(s_ff_k),
    .ff_q(s_ff_q), .busy(s_busy), .fill(s_fill), .err(s_err), .err_count(s_err_count)
  );

  // Behavioural JK flip-flop in the lab datapath; stuck forces its Q output to 0.
  logic ff_state = 1'b0;
  logic stuck;
  assign ff_q   = stuck ? 1'b0 : ff_state;
  assign s_ff_q = 1'b0;
  always @(posedge clk) begin
    if (ff_enabled) begin
      case ({ff_j, ff_k})
        2'b10:   ff_state <= 1'b1;
        2'b01:   ff_state <= 1'b0;
        2'b11:   ff_state <= ~ff_state;
        default: ff_state <= ff_state;
      endcase
    end
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit sb_q[$];
  logic [1:0] jk_log[$];
  int mfill      = 0;
  int exp_err    = 0;
  int pulses     = 0;
  int last_pulse = -1;
  bit chk_spacing = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every command pulse is matched against the oldest target and the observed Q.
  always @(negedge clk) begin
    bit t, q, ej, ek, q_after;
    if (!reset && ff_enabled) begin
      pulses++;
      mfill--;
      jk_log.push_back({ff_j, ff_k});
      if (chk_spacing && last_pulse >= 0) check("pulse_spacing", cyc - last_pulse, 2);
      last_pulse = cyc;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_pulse actual=1 required=0 (t=%0t)", $time);
      end else begin
        t = sb_q.pop_front();
        q = ff_q;
        if (t == q) begin ej = 0; ek = 0; end
        else if (t)  begin ej = 1; ek = 0; end
        else         begin ej = 0; ek = 1; end
        check("cmd_j", int'(ff_j), int'(ej));
        check("cmd_k", int'(ff_k), int'(ek));
        q_after = stuck ? 1'b0 : t;
        if (q_after != t && exp_err < (1 << CNT_W) - 1) exp_err++;
      end
    end
  end

  task automatic push(input bit b);
    in_valid = 1'b1;
    in_bit   = b;
    @(posedge clk);
    if (mfill < DEPTH) begin
      mfill++;
      sb_q.push_back(b);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", sb_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    sb_q.delete();
    mfill   = 0;
    exp_err = 0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=1 required=0");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int s_exp;
    logic [1:0] exp_jk[5];
    bit nbits[5];
    reset = 1'b1; in_valid = 0; in_bit = 0; go = 0; err_clr = 0; stuck = 0;
    s_in_valid = 0; s_in_bit = 0; s_go = 0; s_err_clr = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_fill", int'(fill), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    check("rst_err_count", int'(err_count), 0);
    check("rst_ff_enabled", int'(ff_enabled), 0);

    // Asynchronous reset mid-command with 3 entries still queued
    @(posedge clk); #1;
    push(1); push(0); push(1); push(1);
    go = 1'b1;
    @(posedge clk);
    #1 check("pre_reset_en", int'(ff_enabled), 1);
    #1 reset = 1'b1;
    #1;
    check("arst_en", int'(ff_enabled), 0);
    check("arst_j", int'(ff_j), 0);
    check("arst_k", int'(ff_k), 0);
    check("arst_fill", int'(fill), 0);
    check("arst_in_ready", int'(in_ready), 1);
    check("arst_busy", int'(busy), 0);
    check("arst_err_count", int'(err_count), 0);
    sb_q.delete(); mfill = 0; exp_err = 0; go = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Normal stream 1,0,0,1,1 from Q=0
    pulses = 0; last_pulse = -1; jk_log.delete(); chk_spacing = 1'b1;
    go = 1'b1;
    nbits = '{1, 0, 0, 1, 1};
    for (int i = 0; i < 5; i++) push(nbits[i]);
    drain();
    chk_spacing = 1'b0;
    check("norm_pulses", pulses, 5);
    exp_jk = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b00};
    for (int i = 0; i < 5; i++) begin
      if (i < jk_log.size()) check($sformatf("norm_jk%0d", i), int'(jk_log[i]), int'(exp_jk[i]));
    end
    check("norm_final_q", int'(ff_q), 1);
    check("norm_err_count", int'(err_count), exp_err);
    check("norm_err", int'(err), 0);

    // Full FIFO: DEPTH+2 pushes with go low
    go = 1'b0; pulses = 0;
    for (int i = 0; i < DEPTH + 2; i++) push(1'($urandom));
    @(negedge clk);
    check("full_fill", int'(fill), mfill);
    check("full_fill_depth", int'(fill), DEPTH);
    check("full_in_ready", int'(in_ready), 0);
    @(posedge clk); #1 go = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ff_enabled && n < 20) begin @(negedge clk); n++; end
    check("full_first_pop_seen", int'(ff_enabled), 1);
    check("full_in_ready_after_pop", int'(in_ready), 1);
    check("full_fill_after_pop", int'(fill), DEPTH - 1);
    drain();
    check("full_pulses", pulses, DEPTH);
    check("full_err_count", int'(err_count), exp_err);

    // go dropped while in WAIT with items queued
    go = 1'b0; pulses = 0;
    push(1); push(0); push(1);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("godrop_pulses", pulses, 1);
    check("godrop_fill", int'(fill), 2);
    check("godrop_busy", int'(busy), 0);
    go = 1'b1;
    drain();
    check("godrop_err_count", int'(err_count), exp_err);

    // Stuck-at-0 FF output
    do_reset();
    stuck = 1'b1; go = 1'b1; pulses = 0;
    push(1); push(1);
    drain();
    check("stuck_pulses", pulses, 2);
    check("stuck_err", int'(err), 1);
    check("stuck_err_count", int'(err_count), exp_err);
    check("stuck_err_count_2", int'(err_count), 2);
    stuck = 1'b0;

    // Randomized traffic with go toggling
    do_reset();
    for (int i = 0; i < 60; i++) begin
      go = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) push(1'($urandom));
      else begin @(posedge clk); #1; end
    end
    go = 1'b1;
    drain();
    check("rand_fill", int'(fill), 0);
    check("rand_err_count", int'(err_count), exp_err);

    // Saturation on the narrow counter: 5 mismatches into a 2-bit count
    s_go = 1'b1; s_in_bit = 1'b1;
    s_exp = 0;
    for (int i = 0; i < 5; i++) begin
      s_in_valid = 1'b1;
      @(posedge clk);
      #1 s_in_valid = 1'b0;
      @(posedge clk); #1;
      if (s_exp < (1 << S_CNT_W) - 1) s_exp++;
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("sat_err_count", int'(s_err_count), s_exp);
    check("sat_err", int'(s_err), 1);

    // err_clr on the same edge as a mismatch
    @(posedge clk); #1 s_in_valid = 1'b1;
    @(posedge clk); #1 s_in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!s_ff_enabled && n < 20) begin @(negedge clk); n++; end
    check("clr_cmd_j", int'(s_ff_j), 1);
    @(posedge clk); #1 s_err_clr = 1'b1;
    @(posedge clk); #1 s_err_clr = 1'b0;
    check("clr_mismatch_err_count", int'(s_err_count), 1);
    check("clr_mismatch_err", int'(s_err), 1);
    @(posedge clk); #1 s_err_clr = 1'b1;
    @(posedge clk); #1 s_err_clr = 1'b0;
    check("clr_plain_err_count", int'(s_err_count), 0);
    check("clr_plain_err", int'(s_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jk_drive_sequencer.md
Name: jk_drive_sequencer

Overview:
- Initiator side of the JK flip-flop control interface (clk, reset, enabled, J, K, Q).
- Accepts a buffered stream of desired Q values and converts each into a one-cycle enabled/J/K command for a downstream FF_JK, using the excitation table.
- Reads the FF's Q back, checks each commanded transition and counts mismatches.
- Drives the enabled/J/K inputs of an external FF_JK in the lab datapath.

Parameters:
- DEPTH, 8, target FIFO entries; power of 2, minimum 2.
- CNT_W, 8, width of the mismatch counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  target bit offered.
- in_bit  input  1  desired next Q value.
- in_ready  output  1  FIFO can accept; high when not full.
- go  input  1  level; permits issuing commands.
- err_clr  input  1  synchronous pulse; clears err and err_count.
- ff_enabled  output  1  to FF_JK enabled.
- ff_j  output  1  to FF_JK J.
- ff_k  output  1  to FF_JK K.
- ff_q  input  1  Q fed back from FF_JK.
- busy  output  1  high when FSM is not in IDLE.
- fill  output  log2(DEPTH)+1  FIFO occupancy.
- err  output  1  sticky mismatch flag.
- err_count  output  CNT_W  saturating mismatch count.

Behaviour:
- Reset, asynchronous and immediate:
  - ff_enabled, ff_j, ff_k, err, err_count, fill and busy go to 0; in_ready goes to 1.
  - FIFO is emptied and FSM goes to IDLE.
  - Applies from any state, including mid-command.
- FIFO:
  - Push when in_valid && in_ready.
  - Pop only on an issue edge.
  - Push and pop on the same edge leave fill unchanged.
  - When full, in_ready=0 and no push occurs, even if a pop happens on the same edge.
  - Pointers wrap modulo DEPTH.
- Excitation, decided from ff_q sampled at the issue edge (q) and the popped target (t):
  - q=0, t=0 -> J=0, K=0
  - q=0, t=1 -> J=1, K=0
  - q=1, t=0 -> J=0, K=1
  - q=1, t=1 -> J=0, K=0
  - Don't-cares are always driven as 0; J=K=1 is never emitted.
- FSM states: IDLE, WAIT, CHECK.
  - IDLE:
    - Outputs 0.
    - If go && fill!=0: pop, register ff_enabled=1 with the computed J/K, latch exp=t, go to WAIT.
  - WAIT, one cycle; the FF samples the command on this edge:
    - Register ff_enabled=0, ff_j=0, ff_k=0.
    - Go to CHECK.
  - CHECK:
    - Compare ff_q with exp. On mismatch, set err=1 and increment err_count, saturating at all ones.
    - Same edge: if go && fill!=0, issue the next command as in IDLE (using current ff_q) and go to WAIT; otherwise go to IDLE.
- Timing:
  - Command outputs are registered and high for exactly one cycle.
  - Throughput is one target per 2 cycles.
  - Check latency is 2 edges after the issue edge.
- go dropped while in WAIT or CHECK: the in-flight item completes its check, then the FSM returns to IDLE. No new pop occurs.
- err_clr:
  - Clears err and err_count.
  - If it coincides with a mismatch in CHECK, the result is err=1, err_count=1.
- After a mismatch the next command is computed from the actual ff_q (self-correcting); no retry of the failed target.

Test Plan:
- Reset:
  - Assert reset at #2 mid-cycle while in WAIT with 3 entries queued -> ff_enabled/J/K drop to 0 before the next edge.
  - fill=0, in_ready=1, busy=0, err_count=0.
- Normal stream:
  - Bench: behavioural FF_JK loop, initial Q=0, go=1, push 1,0,0,1,1.
  - Required (J,K) per command: (1,0),(0,1),(0,0),(1,0),(0,0).
  - ff_enabled pulses 5 times, 2 cycles apart; Q sequence 1,0,0,1,1; err_count=0.
- Full FIFO:
  - go=0, push DEPTH+2 bits -> in_ready=0 after 8 pushes, fill=8, last 2 not stored.
  - Then go=1 -> in_ready=1 the edge after the first pop.
- Stuck-at-0 fault:
  - ff_q tied 0, push 1,1 -> both commands are (J=1,K=0); err=1, err_count=2.
- Counter rules:
  - CNT_W=2 with 5 forced mismatches -> err_count saturates at 3.
  - err_clr on the same edge as a mismatch -> err_count=1, err=1.
- go deasserted in WAIT with 2 queued -> one check completes, FSM goes to IDLE, fill=2, no further ff_enabled pulse.
